// File: rtl/bram_read_responder.sv
// Block-RAM read responder for the cache-to-SDRAM read interface.
// It returns burst reads after a fixed, emulated access latency and takes
// scene-loader writes on an independent port.
module bram_read_responder #(
  parameter int unsigned MAX_TRANS = 16,
  parameter int unsigned MEM_WORDS = 8192,
  parameter int unsigned LAT       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         readReq,
  input  logic [24:0]                  addr_cache_to_sdram,
  input  logic [$clog2(MAX_TRANS)-1:0] transSize,
  output logic                         readValid_out,
  output logic [31:0]                  readData,
  output logic                         doneRead,
  input  logic                         writeReq,
  input  logic [24:0]                  sl_addr,
  input  logic [31:0]                  writeData,
  output logic                         doneWrite,
  output logic                         req_err
);

  localparam int unsigned AW     = 25;
  localparam int unsigned DW     = 32;
  localparam int unsigned SIZE_W = $clog2(MAX_TRANS);
  localparam int unsigned BEAT_W = SIZE_W + 1;
  localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W  = 4;
  localparam logic [AW-1:0] MEM_LIM = AW'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t state, state_next;

  logic [DW-1:0]     mem [MEM_WORDS];
  logic [CNT_W-1:0]  lat_cnt;
  logic [AW-1:0]     rd_addr;
  logic [SIZE_W-1:0] size_q;
  logic [BEAT_W-1:0] beat_cnt;

  logic              accept_c;
  logic              issue_c;
  logic              drop_c;
  logic [AW-1:0]     issue_addr_c;
  logic              rd_in_range_c;
  logic              wr_in_range_c;

  assign rd_in_range_c = (issue_addr_c < MEM_LIM);
  assign wr_in_range_c = (sl_addr < MEM_LIM);

  // Next state plus read-issue control. A BRAM read is issued one cycle
  // before the beat it produces, so the first read happens on leaving WAIT.
  always_comb begin
    state_next   = state;
    accept_c     = 1'b0;
    issue_c      = 1'b0;
    drop_c       = 1'b0;
    issue_addr_c = rd_addr;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (readReq) begin
          accept_c     = 1'b1;
          issue_addr_c = addr_cache_to_sdram;
          if (LAT == 1) begin
            if (transSize != '0) begin
              state_next = BURST;
              issue_c    = 1'b1;
            end else begin
              state_next = DONE;
            end
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        drop_c = readReq;
        // The counter reaches zero on this edge, so this is the last wait cycle.
        if (lat_cnt == CNT_W'(1)) begin
          if (size_q != '0) begin
            state_next = BURST;
            issue_c    = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      BURST: begin
        drop_c = readReq;
        if (beat_cnt == BEAT_W'(size_q)) begin
          state_next = DONE;
        end else begin
          issue_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Burst bookkeeping, registered outputs and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt       <= '0;
      rd_addr       <= '0;
      size_q        <= '0;
      beat_cnt      <= '0;
      readValid_out <= 1'b0;
      readData      <= '0;
      doneRead      <= 1'b0;
      doneWrite     <= 1'b0;
      req_err       <= 1'b0;
    end else begin
      if (accept_c) begin
        size_q  <= transSize;
        lat_cnt <= CNT_W'(LAT - 1);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end

      if (issue_c) begin
        rd_addr <= issue_addr_c + AW'(1);
      end else if (accept_c) begin
        rd_addr <= addr_cache_to_sdram;
      end

      if (issue_c) begin
        beat_cnt <= (state == BURST) ? beat_cnt + BEAT_W'(1) : BEAT_W'(1);
        readData <= rd_in_range_c ? mem[issue_addr_c[MEM_AW-1:0]] : '0;
      end

      readValid_out <= issue_c;
      doneRead      <= (state_next == DONE);
      doneWrite     <= writeReq;
      req_err       <= req_err | drop_c | (issue_c & ~rd_in_range_c)
                     | (writeReq & ~wr_in_range_c);
    end
  end

  // Scene-loader write port; the contents survive reset.
  always_ff @(posedge clk) begin
    if (writeReq && wr_in_range_c) begin
      mem[sl_addr[MEM_AW-1:0]] <= writeData;
    end
  end

endmodule
